// File: rtl/systolic_drain.sv
// systolic_drain
// Output drain stage behind the systolic FP-INT MAC array. A rising edge on
// done_in snapshots every per-PE accumulator and exponent. Each element is
// then converted to IEEE FP16 and streamed row-major over valid/ready. The
// array is therefore free to start its next tile while results drain.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-low reset
//   done_in    array done; a rising edge captures the tile
//   acc_in     N*N accumulators, PE i at [i*ACC_WIDTH +: ACC_WIDTH]
//   exp_in     N*N 5-bit exponents, PE i at [i*5 +: 5]
//   out_valid  out_data / out_idx / out_last are valid
//   out_ready  consumer accepts when out_valid && out_ready
//   out_data   FP16 result
//   out_idx    PE index of out_data
//   out_last   high with element N*N-1
//   busy       high whenever the FSM is not IDLE
//   overrun    sticky: a done edge arrived while busy
//
// Build option: define DRAIN_ROUND_EN to round the mantissa to nearest-even.
// When it is not defined, dropped mantissa bits are truncated.
module systolic_drain #(
    parameter int N         = 2,
    parameter int ACC_WIDTH = 32,
    parameter int FRAC_BITS = 10,
    parameter int IDX_W     = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       done_in,
    input  logic [N*N*ACC_WIDTH-1:0]   acc_in,
    input  logic [N*N*5-1:0]           exp_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_data,
    output logic [IDX_W-1:0]           out_idx,
    output logic                       out_last,
    output logic                       busy,
    output logic                       overrun
);

    localparam int P_W = $clog2(ACC_WIDTH);
    localparam int E_W = 10;
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(N*N-1);
    localparam logic signed [E_W-1:0] E_MAX    = 10'sd31;
    localparam logic signed [E_W-1:0] E_ZERO   = 10'sd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t                   state_r;
    logic                     done_d_r;
    logic [N*N*ACC_WIDTH-1:0] snap_acc_r;
    logic [N*N*5-1:0]         snap_exp_r;
    logic [IDX_W-1:0]         idx_r;
    logic                     capture_s;
    logic [ACC_WIDTH-1:0]     cur_acc_s;
    logic [4:0]               cur_exp_s;

    // Fixed-point accumulator scaled by 2^(exp-15-FRAC_BITS) -> FP16.
    function automatic logic [15:0] to_fp16(input logic [ACC_WIDTH-1:0] acc,
                                            input logic [4:0]           ex);
        logic                     s;
        logic [ACC_WIDTH-1:0]     m;
        logic [ACC_WIDTH-1:0]     norm;
        logic [P_W-1:0]           p;
        logic signed [E_W-1:0]    e;
        logic [9:0]               mant;
        logic [15:0]              res;
`ifdef DRAIN_ROUND_EN
        logic                     guard;
        logic                     sticky;
`endif
        s = acc[ACC_WIDTH-1];
        // Magnitude as unsigned so the most negative value stays exact.
        m = s ? (~acc + {{(ACC_WIDTH-1){1'b0}}, 1'b1}) : acc;
        p = '0;
        for (int i = 0; i < ACC_WIDTH; i++) begin
            if (m[i]) begin
                p = P_W'(i);
            end else begin
                p = p;
            end
        end
        // Left-justify so the leading one sits at the MSB.
        norm = m << (P_W'(ACC_WIDTH-1) - p);
        mant = norm[ACC_WIDTH-2 -: 10];
        e    = E_W'(ex) + E_W'(p) - E_W'(FRAC_BITS);
`ifdef DRAIN_ROUND_EN
        guard  = norm[ACC_WIDTH-12];
        sticky = |norm[ACC_WIDTH-13:0];
        if (guard && (sticky || mant[0])) begin
            if (mant == 10'h3FF) begin
                mant = 10'h000;
                e    = e + 10'sd1;
            end else begin
                mant = mant + 10'd1;
            end
        end else begin
            mant = mant;
        end
`endif
        if (m == '0) begin
            res = 16'h0000;
        end else if (e >= E_MAX) begin
            res = {s, 15'h7BFF};
        end else if (e <= E_ZERO) begin
            res = 16'h0000;
        end else begin
            res = {s, e[4:0], mant};
        end
        return res;
    endfunction

    assign capture_s = done_in && !done_d_r;
    assign cur_acc_s = snap_acc_r[idx_r*ACC_WIDTH +: ACC_WIDTH];
    assign cur_exp_s = snap_exp_r[idx_r*5 +: 5];

    // Drain FSM: capture, convert one element, hold it until accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= IDLE;
            done_d_r   <= 1'b1;
            snap_acc_r <= '0;
            snap_exp_r <= '0;
            idx_r      <= '0;
            out_valid  <= 1'b0;
            out_data   <= 16'h0000;
            out_idx    <= '0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            done_d_r <= done_in;
            // A new tile while draining is dropped and flagged.
            if (capture_s && (state_r != IDLE)) begin
                overrun <= 1'b1;
            end else begin
                overrun <= overrun;
            end
            case (state_r)
                IDLE: begin
                    if (capture_s) begin
                        snap_acc_r <= acc_in;
                        snap_exp_r <= exp_in;
                        idx_r      <= '0;
                        busy       <= 1'b1;
                        state_r    <= CONV;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                CONV: begin
                    out_data  <= to_fp16(cur_acc_s, cur_exp_s);
                    out_idx   <= idx_r;
                    out_last  <= (idx_r == LAST_IDX);
                    out_valid <= 1'b1;
                    state_r   <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            busy    <= 1'b0;
                            state_r <= IDLE;
                        end else begin
                            idx_r   <= idx_r + IDX_W'(1);
                            state_r <= CONV;
                        end
                    end else begin
                        state_r <= SEND;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_drain.sv
module tb_systolic_drain;

    localparam int N     = 2;
    localparam int ACCW  = 32;
    localparam int FRAC  = 10;
    localparam int IDX_W = 2;
    localparam int NE    = N*N;

    typedef struct {
        logic [15:0]      data;
        logic [IDX_W-1:0] idx;
        logic             last;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  done_in = 1'b0;
    logic [NE*ACCW-1:0]    acc_in = '0;
    logic [NE*5-1:0]       exp_in = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic [15:0]           out_data;
    logic [IDX_W-1:0]      out_idx;
    logic                  out_last;
    logic                  busy;
    logic                  overrun;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    logic [31:0] t_acc [NE];
    logic [4:0]  t_exp [NE];
    logic [15:0] t_res [NE];

    systolic_drain #(.N(N), .ACC_WIDTH(ACCW), .FRAC_BITS(FRAC), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .done_in   (done_in),
        .acc_in    (acc_in),
        .exp_in    (exp_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, want, $time);
        end
    endtask

    // Reference conversion done in real arithmetic.
    function automatic logic [15:0] model(input logic [31:0] a, input logic [4:0] ex);
        longint la;
        real    v;
        real    f;
        real    fl;
        int     e;
        int     eb;
        int     mi;
        logic   s;
        logic [4:0] eb5;
        logic [9:0] m10;
        if (a == 32'h0) return 16'h0000;
        s  = a[31];
        la = longint'($signed(a));
        if (la < 0) la = -la;
        v = la;
        e = 0;
        while (v >= 2.0) begin v = v / 2.0; e++; end
        while (v < 1.0)  begin v = v * 2.0; e--; end
        eb = e + int'(ex) - FRAC;
        f  = (v - 1.0) * 1024.0;
        fl = $floor(f);
        mi = $rtoi(fl);
`ifdef DRAIN_ROUND_EN
        if ((f - fl > 0.5) || ((f - fl == 0.5) && (mi % 2 == 1))) mi++;
        if (mi == 1024) begin mi = 0; eb++; end
`endif
        if (eb >= 31) return {s, 15'h7BFF};
        if (eb <= 0)  return 16'h0000;
        eb5 = eb[4:0];
        m10 = mi[9:0];
        return {s, eb5, m10};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Put the t_* tile on the inputs and queue its expected stream.
    task automatic load_tile();
        exp_t x;
        for (int i = 0; i < NE; i++) begin
            acc_in[i*ACCW +: ACCW] = t_acc[i];
            exp_in[i*5 +: 5]       = t_exp[i];
            x.data = t_res[i];
            x.idx  = IDX_W'(i);
            x.last = (i == NE-1);
            sb_q.push_back(x);
        end
    endtask

    task automatic pulse_done();
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        tick();
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        check("valid_wait", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && (busy || sb_q.size() != 0); i++) tick();
        check("drain_done", {31'd0, (!busy && sb_q.size() == 0)}, 32'd1);
    endtask

    // With out_ready low, hand over elements one at a time until target shows.
    task automatic step_to(input int target);
        bit found = 0;
        for (int k = 0; k < NE && !found; k++) begin
            wait_valid();
            if (int'(out_idx) == target) begin
                found = 1;
            end else begin
                out_ready = 1'b1;
                tick();
                out_ready = 1'b0;
            end
        end
        check("step_to", {31'd0, found}, 32'd1);
    endtask

    task automatic basic_tile();
        t_acc[0] = 32'hFFFFF000; t_acc[1] = 32'hFFFFF000;
        t_acc[2] = 32'hFFFFF400; t_acc[3] = 32'hFFFFF400;
        for (int i = 0; i < NE; i++) t_exp[i] = 5'd15;
        t_res[0] = 16'hC400; t_res[1] = 16'hC400;
        t_res[2] = 16'hC200; t_res[3] = 16'hC200;
    endtask

    // Scoreboard: every accepted beat is compared with the queue head.
    always @(negedge clk) begin
        exp_t x;
        if (rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_beat", {16'd0, out_data}, 32'hFFFFFFFF);
            end else begin
                x = sb_q.pop_front();
                check("data", {16'd0, out_data}, {16'd0, x.data});
                check("idx",  {{(32-IDX_W){1'b0}}, out_idx}, {{(32-IDX_W){1'b0}}, x.idx});
                check("last", {31'd0, out_last}, {31'd0, x.last});
            end
        end
    end

    initial begin
        // Reset with done_in held high through release.
        done_in = 1'b1;
        repeat (3) tick();
        check("rst_valid",   {31'd0, out_valid}, 32'd0);
        check("rst_busy",    {31'd0, busy},      32'd0);
        check("rst_overrun", {31'd0, overrun},   32'd0);
        check("rst_data",    {16'd0, out_data},  32'd0);
        rst = 1'b1;
        repeat (4) tick();
        check("held_done_no_capture", {31'd0, busy}, 32'd0);
        done_in = 1'b0;
        tick();

        // Basic drain at full throughput.
        basic_tile();
        load_tile();
        pulse_done();
        wait_drain();
        check("busy_after_drain", {31'd0, busy}, 32'd0);

        // Backpressure on idx 1.
        out_ready = 1'b0;
        load_tile();
        pulse_done();
        step_to(1);
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_data",  {16'd0, out_data},  32'h0000C400);
            check("bp_idx",   {30'd0, out_idx},   32'd1);
            tick();
        end
        out_ready = 1'b1;
        wait_drain();

        // Boundaries.
        t_acc[0] = 32'h00000000; t_exp[0] = 5'd15; t_res[0] = 16'h0000;
        t_acc[1] = 32'h7FFFFFFF; t_exp[1] = 5'd30; t_res[1] = 16'h7BFF;
        t_acc[2] = 32'h80000000; t_exp[2] = 5'd30; t_res[2] = 16'hFBFF;
        t_acc[3] = 32'h00000001; t_exp[3] = 5'd1;  t_res[3] = 16'h0000;
        load_tile();
        pulse_done();
        wait_drain();

        // Rounding case plus model-checked neighbours.
        t_acc[0] = 32'h00000FFF; t_exp[0] = 5'd15;
`ifdef DRAIN_ROUND_EN
        t_res[0] = 16'h4400;
`else
        t_res[0] = 16'h43FF;
`endif
        t_acc[1] = 32'hFFFFF001; t_exp[1] = 5'd15; t_res[1] = model(t_acc[1], t_exp[1]);
        t_acc[2] = 32'h00000C01; t_exp[2] = 5'd20; t_res[2] = model(t_acc[2], t_exp[2]);
        t_acc[3] = 32'h12345678; t_exp[3] = 5'd2;  t_res[3] = model(t_acc[3], t_exp[3]);
        load_tile();
        pulse_done();
        wait_drain();

        // Random tiles against the model.
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < NE; i++) begin
                t_acc[i] = $urandom() >> $urandom_range(0, 31);
                if ($urandom_range(0, 1) == 1) t_acc[i] = -t_acc[i];
                t_exp[i] = 5'($urandom_range(0, 31));
                t_res[i] = model(t_acc[i], t_exp[i]);
            end
            out_ready = (t % 2 == 0);
            load_tile();
            pulse_done();
            if (t % 2 == 1) begin
                step_to(2);
                repeat (3) tick();
                out_ready = 1'b1;
            end
            wait_drain();
        end

        // Overrun: second done edge while holding idx 1.
        out_ready = 1'b0;
        basic_tile();
        load_tile();
        pulse_done();
        step_to(1);
        for (int i = 0; i < NE; i++) acc_in[i*ACCW +: ACCW] = 32'h00001000;
        pulse_done();
        check("overrun_set", {31'd0, overrun}, 32'd1);
        check("overrun_hold_idx", {30'd0, out_idx}, 32'd1);
        out_ready = 1'b1;
        wait_drain();

        // done_in held high for many cycles captures once.
        load_tile();
        done_in = 1'b1;
        repeat (25) tick();
        done_in = 1'b0;
        wait_drain();
        repeat (5) tick();
        check("single_capture", {31'd0, busy}, 32'd0);
        check("overrun_sticky", {31'd0, overrun}, 32'd1);

        // Reset mid-stream while holding idx 2.
        out_ready = 1'b0;
        load_tile();
        pulse_done();
        step_to(2);
        rst = 1'b0;
        tick();
        check("mid_rst_valid",   {31'd0, out_valid}, 32'd0);
        check("mid_rst_busy",    {31'd0, busy},      32'd0);
        check("mid_rst_overrun", {31'd0, overrun},   32'd0);
        rst = 1'b1;
        sb_q.delete();
        tick();
        out_ready = 1'b1;
        t_acc[0] = 32'h00000400; t_exp[0] = 5'd15; t_res[0] = 16'h3C00;
        t_acc[1] = 32'hFFFFFC00; t_exp[1] = 5'd16; t_res[1] = 16'hC000;
        t_acc[2] = 32'h00000600; t_exp[2] = 5'd15; t_res[2] = 16'h3E00;
        t_acc[3] = 32'h00000200; t_exp[3] = 5'd15; t_res[3] = 16'h3800;
        load_tile();
        pulse_done();
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
